// File: rtl/ahb_apb_bridge_mc_pkg.sv
// Shared AHB/APB types: transfer/response encodings and bridge FSM states.
package ahb_apb_pkg;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
  typedef enum logic [1:0] {HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01} hresp_t;
  typedef enum logic [2:0] {ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} bridge_state_t;

  // Slave index width; a single completer still needs a 1-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ahb_apb_bridge_mc_if.sv
// AHB slave port plus APB completer bundle seen by the bridge.
interface ahb_apb_bridge_mc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic                             HSEL;
  logic [ADDR_WIDTH-1:0]            HADDR;
  logic [1:0]                       HTRANS;
  logic                             HWRITE;
  logic                             HREADY_IN;
  logic [DATA_WIDTH-1:0]            HWDATA;
  logic [DATA_WIDTH-1:0]            HRDATA;
  logic [1:0]                       HRESP;
  logic                             HREADY_OUT;
  logic [NUM_SLAVES-1:0]            PSEL;
  logic                             PENABLE;
  logic                             PWRITE;
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]            PREADY;
  logic [NUM_SLAVES-1:0]            PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HREADY_IN, HWDATA, PRDATA, PREADY, PSLVERR,
    output HRDATA, HRESP, HREADY_OUT, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HREADY_IN, HWDATA, PRDATA, PREADY, PSLVERR,
    input  HRDATA, HRESP, HREADY_OUT, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/ahb_apb_bridge_mc_dec.sv
// Extracts the APB completer index from an address and flags indices with no completer.
module apb_addr_decoder import ahb_apb_pkg::*; #(
  parameter int NUM_SLAVES    = 4,
  parameter int SLAVE_SEL_LSB = 12,
  parameter int ADDR_WIDTH    = 32,
  localparam int IDX_W        = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      index,
  output logic                  decode_err
);
  logic unused_addr;
  assign unused_addr = ^addr;

  generate
    if (NUM_SLAVES == 1) begin : g_one
      assign index      = '0;
      assign decode_err = 1'b0;
    end else begin : g_multi
      assign index      = addr[SLAVE_SEL_LSB +: IDX_W];
      assign decode_err = (32'(index) >= 32'(NUM_SLAVES));
    end
  endgenerate
endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite slave to multi-completer APB bridge with wait states, error mapping and optional timeout.
module ahb_apb_bridge_mc import ahb_apb_pkg::*; #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLAVE_SEL_LSB  = 12,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic               HCLK,
  input logic               HRESET,
  ahb_apb_bridge_mc_if.slave bus
);
  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  bridge_state_t state, state_nxt, start_state;
  logic [IDX_W-1:0] idx_dec, idx_q;
  logic             dec_err, err_q;
  logic [TW-1:0]    tcnt;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] prdata_arr;
  logic             valid, cap, sel_ready, sel_err, done_ok, timeout;
  logic             unused_htrans;

  apb_addr_decoder #(
    .NUM_SLAVES(NUM_SLAVES), .SLAVE_SEL_LSB(SLAVE_SEL_LSB), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dec (
    .addr(bus.HADDR), .index(idx_dec), .decode_err(dec_err)
  );

  assign unused_htrans = bus.HTRANS[0];
  assign prdata_arr    = bus.PRDATA;
  assign valid         = bus.HSEL & bus.HTRANS[1] & bus.HREADY_IN;
  assign sel_ready     = bus.PREADY[idx_q];
  assign sel_err       = bus.PSLVERR[idx_q];
  assign done_ok       = (state == ST_ACCESS) && sel_ready && !sel_err;
  assign timeout       = (TIMEOUT_CYCLES != 0) && (state == ST_ACCESS) && !sel_ready && (tcnt == TO_LAST);
  // A new address phase is only taken on cycles that present HREADY_OUT high.
  assign cap           = bus.HREADY_OUT && valid;
  assign start_state   = !valid ? ST_IDLE : bus.HWRITE ? ST_WDATA : dec_err ? ST_ERR1 : ST_SETUP;

  always_comb begin
    state_nxt      = state;
    bus.HREADY_OUT = 1'b1;
    bus.HRESP      = HRESP_OKAY;
    bus.HRDATA     = '0;
    bus.PSEL       = '0;
    bus.PENABLE    = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = start_state;
      ST_WDATA: begin
        bus.HREADY_OUT = 1'b0;
        state_nxt      = err_q ? ST_ERR1 : ST_SETUP;
      end
      ST_SETUP: begin
        bus.HREADY_OUT = 1'b0;
        bus.PSEL       = NUM_SLAVES'(1) << idx_q;
        state_nxt      = ST_ACCESS;
      end
      ST_ACCESS: begin
        bus.PSEL       = NUM_SLAVES'(1) << idx_q;
        bus.PENABLE    = 1'b1;
        bus.HREADY_OUT = done_ok;
        if (sel_ready) begin
          if (sel_err) state_nxt = ST_ERR1;
          else begin
            state_nxt = start_state;
            if (!bus.PWRITE) bus.HRDATA = prdata_arr[idx_q];
          end
        end else if (timeout) begin
          state_nxt = ST_ERR1;
        end
      end
      ST_ERR1: begin
        bus.HREADY_OUT = 1'b0;
        bus.HRESP      = HRESP_ERROR;
        state_nxt      = ST_ERR2;
      end
      ST_ERR2: begin
        bus.HRESP = HRESP_ERROR;
        state_nxt = start_state;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      idx_q      <= '0;
      err_q      <= 1'b0;
      tcnt       <= '0;
      bus.PADDR  <= '0;
      bus.PWRITE <= 1'b0;
      bus.PWDATA <= '0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        bus.PADDR  <= bus.HADDR;
        bus.PWRITE <= bus.HWRITE;
        idx_q      <= idx_dec;
        err_q      <= dec_err;
      end
      if (state == ST_WDATA) bus.PWDATA <= bus.HWDATA;
      if (state == ST_SETUP) tcnt <= '0;
      else if ((state == ST_ACCESS) && !sel_ready && (tcnt != '1)) tcnt <= tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// Scoreboarded bench: 4-completer bridge with timeout, plus a 3-completer bridge for decode misses.
module tb_ahb_apb_bridge_mc;
  import ahb_apb_pkg::*;
  localparam int AW = 32, DW = 32, NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_apb_bridge_mc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();
  ahb_apb_bridge_mc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(3))  bus3 ();

  ahb_apb_bridge_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
                      .SLAVE_SEL_LSB(12), .TIMEOUT_CYCLES(4))
    dut (.HCLK(clk), .HRESET(rst), .bus(bus));
  ahb_apb_bridge_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(3),
                      .SLAVE_SEL_LSB(12), .TIMEOUT_CYCLES(0))
    dut3 (.HCLK(clk), .HRESET(rst), .bus(bus3));

  typedef struct { logic [1:0] resp; logic [31:0] rdata; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int wait_n = 0, acc_cnt = 0;
  logic [NS-1:0] slverr = '0;
  bit dphase = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // APB completer model: PREADY rises after wait_n ACCESS cycles.
  assign bus.PREADY  = (acc_cnt >= wait_n) ? '1 : '0;
  assign bus.PSLVERR = slverr;
  assign bus.PRDATA  = {32'hCAFE0003, 32'hCAFEF00D, 32'hCAFE0001, 32'hCAFE0000};
  assign bus3.PREADY  = '1;
  assign bus3.PSLVERR = '0;
  assign bus3.PRDATA  = '0;

  always @(posedge clk)
    if (bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  // AHB data-phase monitor: every HREADY_OUT-high cycle closes a pending data phase.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      dphase = 1'b0;
      sb.delete();
    end else if (bus.HREADY_OUT) begin
      if (dphase) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("resp", bus.HRESP, e.resp);
          chk("rdata", bus.HRDATA, e.rdata);
        end
      end
      dphase = bus.HSEL && bus.HTRANS[1] && bus.HREADY_IN;
    end
  end

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] rsp, input logic [31:0] rd);
    exp_t e;
    bit acc = 1'b0;
    e.resp = rsp; e.rdata = rd;
    sb.push_back(e);
    bus.HSEL = 1'b1; bus.HTRANS = HT_NONSEQ; bus.HWRITE = wr; bus.HADDR = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.HREADY_OUT) begin acc = 1'b1; break; end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = HT_IDLE; bus.HWDATA = d;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic issue3(input bit wr);
    bus3.HSEL = 1'b1; bus3.HTRANS = HT_NONSEQ; bus3.HWRITE = wr; bus3.HADDR = 32'h0000_3000;
    @(negedge clk);
    chk("d3_accept", bus3.HREADY_OUT, 1);
    @(posedge clk); #1;
    bus3.HSEL = 1'b0; bus3.HTRANS = HT_IDLE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.HSEL = 0; bus.HTRANS = HT_IDLE; bus.HWRITE = 0; bus.HADDR = '0; bus.HWDATA = '0; bus.HREADY_IN = 1;
    bus3.HSEL = 0; bus3.HTRANS = HT_IDLE; bus3.HWRITE = 0; bus3.HADDR = '0; bus3.HWDATA = '0; bus3.HREADY_IN = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", bus.PSEL, 0);       chk("rst_penable", bus.PENABLE, 0);
    chk("rst_paddr", bus.PADDR, 0);     chk("rst_pwrite", bus.PWRITE, 0);
    chk("rst_pwdata", bus.PWDATA, 0);   chk("rst_hrdata", bus.HRDATA, 0);
    chk("rst_hresp", bus.HRESP, 0);     chk("rst_hready", bus.HREADY_OUT, 1);
    @(posedge clk); #1 rst = 1'b0;

    // zero-wait read of slave 2
    issue(1'b0, 32'h0000_2004, 32'h0, HRESP_OKAY, 32'hCAFEF00D);
    @(negedge clk);
    chk("rd_t1_psel", bus.PSEL, 4'b0100); chk("rd_t1_pen", bus.PENABLE, 0); chk("rd_t1_hrdy", bus.HREADY_OUT, 0);
    @(negedge clk);
    chk("rd_t2_psel", bus.PSEL, 4'b0100); chk("rd_t2_pen", bus.PENABLE, 1); chk("rd_t2_hrdy", bus.HREADY_OUT, 1);
    chk("rd_paddr", bus.PADDR, 32'h0000_2004);
    drain();

    // write to slave 1 with three wait states
    wait_n = 3;
    issue(1'b1, 32'h0000_1010, 32'h12345678, HRESP_OKAY, 32'h0);
    @(negedge clk);
    chk("wr_t1_hrdy", bus.HREADY_OUT, 0); chk("wr_t1_psel", bus.PSEL, 0);
    @(negedge clk);
    chk("wr_t2_pwdata", bus.PWDATA, 32'h12345678); chk("wr_t2_psel", bus.PSEL, 4'b0010); chk("wr_t2_pen", bus.PENABLE, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_wait_pen", bus.PENABLE, 1); chk("wr_wait_hrdy", bus.HREADY_OUT, 0);
    end
    @(negedge clk);
    chk("wr_t6_pen", bus.PENABLE, 1); chk("wr_t6_hrdy", bus.HREADY_OUT, 1); chk("wr_pwrite", bus.PWRITE, 1);
    drain();
    wait_n = 0;

    // PSLVERR from slave 3
    slverr = 4'b1000;
    issue(1'b0, 32'h0000_3000, 32'h0, HRESP_ERROR, 32'h0);
    @(negedge clk); chk("se_t1_psel", bus.PSEL, 4'b1000);
    @(negedge clk); chk("se_t2_hrdy", bus.HREADY_OUT, 0); chk("se_t2_hresp", bus.HRESP, 0);
    @(negedge clk); chk("se_t3_hresp", bus.HRESP, 1); chk("se_t3_hrdy", bus.HREADY_OUT, 0); chk("se_t3_psel", bus.PSEL, 0);
    drain();
    slverr = '0;

    // PREADY stuck low: timeout after four ACCESS cycles
    wait_n = 1000;
    issue(1'b0, 32'h0000_2000, 32'h0, HRESP_ERROR, 32'h0);
    @(negedge clk); chk("to_t1_pen", bus.PENABLE, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_acc_pen", bus.PENABLE, 1); chk("to_acc_hrdy", bus.HREADY_OUT, 0);
    end
    @(negedge clk);
    chk("to_err1_psel", bus.PSEL, 0); chk("to_err1_pen", bus.PENABLE, 0);
    chk("to_err1_hresp", bus.HRESP, 1); chk("to_err1_hrdy", bus.HREADY_OUT, 0);
    drain();
    wait_n = 0;

    // back-to-back write then read accepted on the write's completing cycle
    issue(1'b1, 32'h0000_1000, 32'hAABBCCDD, HRESP_OKAY, 32'h0);
    issue(1'b0, 32'h0000_3004, 32'h0, HRESP_OKAY, 32'hCAFE0003);
    @(negedge clk);
    chk("b2b_psel", bus.PSEL, 4'b1000); chk("b2b_pen", bus.PENABLE, 0); chk("b2b_pwdata", bus.PWDATA, 32'hAABBCCDD);
    drain();

    // reset during ACCESS abandons the transfer
    wait_n = 1000;
    issue(1'b0, 32'h0000_2008, 32'h0, HRESP_OKAY, 32'h0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("mr_acc_pen", bus.PENABLE, 1);
    @(posedge clk); #1 rst = 1'b0;
    wait_n = 0;
    @(negedge clk);
    chk("mr_psel", bus.PSEL, 0);   chk("mr_pen", bus.PENABLE, 0); chk("mr_hrdy", bus.HREADY_OUT, 1);
    chk("mr_hresp", bus.HRESP, 0); chk("mr_paddr", bus.PADDR, 0); chk("mr_hrdata", bus.HRDATA, 0);
    @(posedge clk); #1;
    issue(1'b0, 32'h0000_2004, 32'h0, HRESP_OKAY, 32'hCAFEF00D);
    drain();

    // decode miss on the 3-completer bridge: read, then write via WDATA
    issue3(1'b0);
    @(negedge clk);
    chk("dm_rd_e1_hrdy", bus3.HREADY_OUT, 0); chk("dm_rd_e1_hresp", bus3.HRESP, 1); chk("dm_rd_e1_psel", bus3.PSEL, 0);
    @(negedge clk);
    chk("dm_rd_e2_hrdy", bus3.HREADY_OUT, 1); chk("dm_rd_e2_hresp", bus3.HRESP, 1); chk("dm_rd_e2_psel", bus3.PSEL, 0);
    @(posedge clk); #1;
    issue3(1'b1);
    @(negedge clk);
    chk("dm_wr_wd_hrdy", bus3.HREADY_OUT, 0); chk("dm_wr_wd_hresp", bus3.HRESP, 0);
    @(negedge clk);
    chk("dm_wr_e1_hrdy", bus3.HREADY_OUT, 0); chk("dm_wr_e1_hresp", bus3.HRESP, 1); chk("dm_wr_e1_psel", bus3.PSEL, 0);
    @(negedge clk);
    chk("dm_wr_e2_hrdy", bus3.HREADY_OUT, 1); chk("dm_wr_e2_hresp", bus3.HRESP, 1);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
